sensor_link_host: RTL and testbench
===================================

# sensor_link_host

Host-side counterpart of the sensor node's string UART link. It parses the ASCII telemetry frames `S:TTHH\n` coming from an RxUnit into binary temperature and humidity values. It also serialises LED command frames `L:ab\n` into a TxUnit. It sits between one RxUnit/TxUnit pair and the host display/control logic, on the board at the far end of the link.

## Interface
- TIMEOUT_CYCLES, 2_000_000, maximum idle gap between bytes inside a frame (20 ms at 100 MHz).
- clk_100Mhz  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- rx_data  input  8  received byte from RxUnit `data_out`.
- rx_done  input  1  one-cycle strobe from RxUnit: rx_data is valid.
- rx_error  input  1  RxUnit parity/stop error; sampled only together with rx_done.
- temperature  output  8  last good temperature, binary 0..99.
- humidity  output  8  last good humidity, binary 0..99.
- frame_valid  output  1  one-cycle pulse: temperature/humidity just updated.
- frame_error  output  1  one-cycle pulse: frame aborted.
- led_cmd  input  2  LED states to send; bit0 → first char, bit1 → second char.
- cmd_send  input  1  request to transmit one command frame.
- cmd_busy  output  1  command frame in progress.
- tx_data  output  8  byte to TxUnit `data_in`.
- tx_send  output  1  to TxUnit `send`; held high while a frame is in progress.
- tx_done  input  1  TxUnit `done_flag`: current byte finished.

## Operation
- RX parser FSM states: WAIT_S, WAIT_COLON, DIG0, DIG1, DIG2, DIG3, WAIT_NL. The FSM advances only on an rx_done cycle.
- WAIT_S: on 'S' (0x53) go to WAIT_COLON. Any other byte is discarded silently, with no error.
- WAIT_COLON: ':' (0x3A) → DIG0.
- DIGn: byte 0x30..0x39 → store (byte − 0x30) in digit register n, then advance.
- WAIT_NL: 0x0A → commit, then return to WAIT_S.
- Commit: temperature = d0*10 + d1 and humidity = d2*10 + d3, using 8-bit unsigned arithmetic (max 99, no overflow). Pulse frame_valid.
- Abort conditions, from any state other than WAIT_S:
  - unexpected byte;
  - rx_error high with rx_done;
  - no rx_done for TIMEOUT_CYCLES.
- Abort action: pulse frame_error, keep temperature/humidity unchanged, go to WAIT_S. If the offending byte is itself 'S' and rx_error is low, go to WAIT_COLON instead (resync).
- rx_error in WAIT_S: byte discarded, no frame_error.
- Timeout counter: cleared on every rx_done and in WAIT_S; saturates at TIMEOUT_CYCLES.
- TX encoder FSM states: T_IDLE, T_SEND.
  - T_IDLE: cmd_send high → latch led_cmd, load byte index 0 ('L'), go to T_SEND.
  - Frame bytes, in order: 0x4C, 0x3A, 0x30+led_cmd[0], 0x30+led_cmd[1], 0x0A.
  - T_SEND: on tx_done, if the index is below 4, increment it and present the next byte. If the index is 4, go to T_IDLE.
- cmd_send while cmd_busy is ignored and is not queued. led_cmd changes during a frame do not affect that frame.
- RX and TX paths are fully independent; simultaneous activity on both is legal.

## Timing
- Reset values:
  - temperature = 0, humidity = 0;
  - frame_valid = 0, frame_error = 0;
  - cmd_busy = 0, tx_send = 0, tx_data = 0x00;
  - RX FSM in WAIT_S, TX FSM in T_IDLE, timeout counter = 0.
- rst asserted mid-frame: both FSMs return to their reset values on the next edge. The partial frame is dropped with no frame_error, and tx_send falls.
- frame_valid, temperature and humidity all update on the edge after the rx_done cycle carrying '\n' (latency 1). Values hold until the next commit.
- frame_error pulses on the edge after the offending rx_done, or on the edge where the timeout counter reaches TIMEOUT_CYCLES.
- cmd_busy, tx_send and tx_data = 0x4C are all valid on the edge after the cmd_send cycle.
- Each tx_done (index < 4): the next tx_data is presented on the following edge, and tx_send stays high.
- tx_done on the '\n' byte: tx_send and cmd_busy are low on the following edge. A cmd_send in that same cycle is ignored.
- The earliest next accepted cmd_send is the cycle after cmd_busy falls.

## Test plan
- Stream "S:2365\n" with gaps of about 1000 cycles → frame_valid pulses once; temperature = 23 (0x17), humidity = 65 (0x41); frame_error never pulses.
- Stream "S:2A65\n" → frame_error pulses at 'A', outputs keep their previous values. A following "S:0099\n" → temperature = 0, humidity = 99.
- Stream "S:1S:4050\n" → frame_error at the second 'S' with resync; frame_valid gives temperature = 40, humidity = 50.
- Stream "S:12", then silence for TIMEOUT_CYCLES → exactly one frame_error. A later full frame parses correctly. Separately, rx_error on the third byte → frame_error, outputs unchanged.
- led_cmd = 2'b10 with cmd_send, using a TxUnit model that returns tx_done 50 cycles after each byte → tx_data sequence 0x4C, 0x3A, 0x30, 0x31, 0x0A. tx_send is high throughout, and cmd_busy falls one cycle after the fifth tx_done. A second cmd_send mid-frame produces no extra bytes.
- rst pulsed during the DIG2 state and during the third TX byte → all outputs return to their reset values next edge. A subsequent frame and command both complete normally.

Source files
------------

// File: rtl/sensor_link_host.sv
// Purpose: parses "S:TTHH\n" telemetry from an RxUnit and serialises "L:ab\n" LED commands into a TxUnit.
// Latency: temperature/humidity/frame_valid one edge after the '\n' strobe; first tx byte one edge after cmd_send.
// Backpressure: none on RX (every rx_done is consumed); TX paced by tx_done, cmd_send ignored while cmd_busy.
module sensor_link_host #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk_100Mhz,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_error,
    output logic [7:0] temperature,
    output logic [7:0] humidity,
    output logic       frame_valid,
    output logic       frame_error,
    input  logic [1:0] led_cmd,
    input  logic       cmd_send,
    output logic       cmd_busy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_L     = 8'h4C;

    typedef enum logic [2:0] {
        WAIT_S, WAIT_COLON, DIG0, DIG1, DIG2, DIG3, WAIT_NL
    } rx_state_t;

    typedef enum logic {
        T_IDLE, T_SEND
    } tx_state_t;

    // ---------------- RX parser ----------------
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] to_cnt;
    logic [3:0]       digit [4];
    logic [3:0]       dig_we;
    logic             commit, abort;
    logic             is_digit;
    logic [7:0]       temp_calc, hum_calc;

    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign temp_calc = {4'd0, digit[0]} * 8'd10 + {4'd0, digit[1]};
    assign hum_calc  = {4'd0, digit[2]} * 8'd10 + {4'd0, digit[3]};

    // Next-state decode: advance on matching bytes, abort on mismatch/line error/timeout.
    always_comb begin
        rx_next = rx_state;
        commit  = 1'b0;
        abort   = 1'b0;
        dig_we  = 4'b0000;
        if (rx_done) begin
            if (rx_state == WAIT_S) begin
                // Line noise and errored bytes between frames are dropped silently.
                if (!rx_error && rx_data == CH_S) rx_next = WAIT_COLON;
            end else if (rx_error) begin
                abort = 1'b1;
            end else begin
                case (rx_state)
                    WAIT_COLON: if (rx_data == CH_COLON) rx_next = DIG0;    else abort = 1'b1;
                    DIG0: if (is_digit) begin dig_we[0] = 1'b1; rx_next = DIG1; end else abort = 1'b1;
                    DIG1: if (is_digit) begin dig_we[1] = 1'b1; rx_next = DIG2; end else abort = 1'b1;
                    DIG2: if (is_digit) begin dig_we[2] = 1'b1; rx_next = DIG3; end else abort = 1'b1;
                    DIG3: if (is_digit) begin dig_we[3] = 1'b1; rx_next = WAIT_NL; end else abort = 1'b1;
                    WAIT_NL: if (rx_data == CH_NL) begin commit = 1'b1; rx_next = WAIT_S; end
                             else abort = 1'b1;
                    default: rx_next = WAIT_S;
                endcase
            end
            // A clean 'S' that breaks a frame is treated as the start of a new one.
            if (abort) rx_next = (!rx_error && rx_data == CH_S) ? WAIT_COLON : WAIT_S;
        end else if (rx_state != WAIT_S && to_cnt == TO_LAST) begin
            abort   = 1'b1;
            rx_next = WAIT_S;
        end
    end

    // RX state, digit capture, committed values and event pulses.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            rx_state    <= WAIT_S;
            temperature <= 8'd0;
            humidity    <= 8'd0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
        end else begin
            rx_state    <= rx_next;
            frame_valid <= commit;
            frame_error <= abort;
            for (int i = 0; i < 4; i++) if (dig_we[i]) digit[i] <= rx_data[3:0];
            if (commit) begin
                temperature <= temp_calc;
                humidity    <= hum_calc;
            end
        end
    end

    // Inter-byte idle counter; only meaningful while inside a frame.
    always_ff @(posedge clk_100Mhz) begin
        if (rst || rx_done || rx_state == WAIT_S) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // ---------------- TX encoder ----------------
    tx_state_t  tx_state, tx_next;
    logic [2:0] tx_idx, idx_next;
    logic [1:0] led_lat, led_next;

    // Next-state and byte mux; led_cmd is latched so mid-frame changes are invisible.
    always_comb begin
        tx_next  = tx_state;
        idx_next = tx_idx;
        led_next = led_lat;
        tx_data  = 8'h00;
        tx_send  = 1'b0;
        cmd_busy = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (cmd_send) begin
                    tx_next  = T_SEND;
                    idx_next = 3'd0;
                    led_next = led_cmd;
                end
            end
            T_SEND: begin
                tx_send  = 1'b1;
                cmd_busy = 1'b1;
                case (tx_idx)
                    3'd0:    tx_data = CH_L;
                    3'd1:    tx_data = CH_COLON;
                    3'd2:    tx_data = {7'b0011000, led_lat[0]};
                    3'd3:    tx_data = {7'b0011000, led_lat[1]};
                    default: tx_data = CH_NL;
                endcase
                if (tx_done) begin
                    if (tx_idx < 3'd4) idx_next = tx_idx + 3'd1;
                    else               tx_next  = T_IDLE;
                end
            end
            default: tx_next = T_IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_idx   <= 3'd0;
            led_lat  <= 2'b00;
        end else begin
            tx_state <= tx_next;
            tx_idx   <= idx_next;
            led_lat  <= led_next;
        end
    end

endmodule

// File: tb/tb_sensor_link_host.sv
module tb_sensor_link_host;

    localparam int TO = 1200;

    logic       clk_100Mhz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] temperature, humidity;
    logic       frame_valid, frame_error;
    logic [1:0] led_cmd = 2'b00;
    logic       cmd_send = 1'b0;
    logic       cmd_busy;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_done = 1'b0;

    sensor_link_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_100Mhz (clk_100Mhz),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_error   (rx_error),
        .temperature(temperature),
        .humidity   (humidity),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .led_cmd    (led_cmd),
        .cmd_send   (cmd_send),
        .cmd_busy   (cmd_busy),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_done    (tx_done)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- RX reference model ----------------
    typedef struct packed {
        logic       is_err;
        logic [7:0] t;
        logic [7:0] h;
    } ev_t;

    ev_t          rx_q[$];
    logic [7:0]   fbuf[$];
    logic [7:0]   good_t = 8'd0;
    logic [7:0]   good_h = 8'd0;

    // Does byte b belong at position pos of the template "S:####\n"?
    function automatic bit fits(input int pos, input logic [7:0] b);
        case (pos)
            1:          return b == 8'h3A;
            2, 3, 4, 5: return (b >= 8'h30) && (b <= 8'h39);
            6:          return b == 8'h0A;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit err);
        ev_t e;
        if (fbuf.size() == 0) begin
            if (!err && b == 8'h53) fbuf.push_back(b);
        end else if (!err && fits(fbuf.size(), b)) begin
            fbuf.push_back(b);
            if (fbuf.size() == 7) begin
                good_t = 8'((fbuf[2] - 8'h30) * 10 + (fbuf[3] - 8'h30));
                good_h = 8'((fbuf[4] - 8'h30) * 10 + (fbuf[5] - 8'h30));
                e = '{1'b0, good_t, good_h};
                rx_q.push_back(e);
                fbuf.delete();
            end
        end else begin
            e = '{1'b1, good_t, good_h};
            rx_q.push_back(e);
            fbuf.delete();
            if (!err && b == 8'h53) fbuf.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit err, input int gap);
        repeat (gap) @(posedge clk_100Mhz);
        #1;
        rx_data  = b;
        rx_error = err;
        rx_done  = 1'b1;
        model_byte(b, err);
        @(posedge clk_100Mhz);
        #1;
        rx_done  = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, gap);
    endtask

    // Go quiet long enough for any open frame to time out.
    task automatic timeout_idle();
        ev_t e;
        if (fbuf.size() != 0) begin
            e = '{1'b1, good_t, good_h};
            rx_q.push_back(e);
            fbuf.delete();
        end
        repeat (TO + 20) @(posedge clk_100Mhz);
        #1;
    endtask

    // RX monitor: every pulse must match the next expected event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk_100Mhz);
            if (!rst && (frame_valid || frame_error)) begin
                if (rx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected: valid=%0b error=%0b, want no event (t=%0t)",
                             frame_valid, frame_error, $time);
                end else begin
                    e = rx_q.pop_front();
                    check("frame_error", frame_error, e.is_err);
                    check("frame_valid", frame_valid, !e.is_err);
                    check("temperature", temperature, e.t);
                    check("humidity", humidity, e.h);
                end
            end
        end
    end

    // ---------------- TxUnit model and TX scoreboard ----------------
    logic [1:0] tx_led_q[$];
    logic [1:0] cur_led = 2'b00;
    bit         tx_inframe = 1'b0;
    int         tx_wait = 0;
    int         tx_pos = 0;

    function automatic logic [7:0] exp_byte(input int pos, input logic [1:0] l);
        case (pos)
            0:       return 8'h4C;
            1:       return 8'h3A;
            2:       return 8'h30 + {7'd0, l[0]};
            3:       return 8'h30 + {7'd0, l[1]};
            default: return 8'h0A;
        endcase
    endfunction

    function automatic bit tx_model_busy();
        return (tx_led_q.size() != 0) || tx_inframe;
    endfunction

    initial begin
        forever begin
            @(negedge clk_100Mhz);
            if (rst) begin
                tx_done    = 1'b0;
                tx_wait    = 0;
                tx_pos     = 0;
                tx_inframe = 1'b0;
            end else if (tx_done) begin
                tx_done = 1'b0;
                if (tx_pos == 5) begin
                    check("tx_send_fall", tx_send, 1'b0);
                    check("cmd_busy_fall", cmd_busy, 1'b0);
                    tx_pos     = 0;
                    tx_inframe = 1'b0;
                end else begin
                    check("tx_send_held", tx_send, 1'b1);
                end
            end else if (tx_send) begin
                if (tx_wait == 0) begin
                    if (tx_pos == 0) begin
                        if (tx_led_q.size() == 0) begin
                            fail_now("tx_unexpected_frame");
                            cur_led = 2'b00;
                        end else begin
                            cur_led = tx_led_q.pop_front();
                        end
                        tx_inframe = 1'b1;
                    end
                    check("tx_data", tx_data, exp_byte(tx_pos, cur_led));
                    check("cmd_busy", cmd_busy, 1'b1);
                end
                tx_wait++;
                if (tx_wait == 50) begin
                    tx_done = 1'b1;
                    tx_wait = 0;
                    tx_pos++;
                end
            end else if (tx_inframe) begin
                fail_now("tx_send_dropped_mid_frame");
                tx_inframe = 1'b0;
                tx_pos     = 0;
                tx_wait    = 0;
            end
        end
    end

    task automatic send_cmd(input logic [1:0] led);
        int w = 0;
        while (tx_model_busy() && w < 2000) begin
            @(posedge clk_100Mhz);
            w++;
        end
        if (w >= 2000) fail_now("tx_idle_wait_expired");
        #1;
        led_cmd  = led;
        cmd_send = 1'b1;
        tx_led_q.push_back(led);
        @(posedge clk_100Mhz);
        #1;
        cmd_send = 1'b0;
        led_cmd  = 2'($urandom);
        check("cmd_busy_rise", cmd_busy, 1'b1);
        check("tx_send_rise", tx_send, 1'b1);
        check("tx_first_byte", tx_data, 8'h4C);
    endtask

    // cmd_send while a frame is in flight; must be ignored.
    task automatic poke_cmd();
        #1;
        led_cmd  = 2'($urandom);
        cmd_send = 1'b1;
        @(posedge clk_100Mhz);
        #1;
        cmd_send = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int w = 0;
        while (tx_model_busy() && w < 2000) begin
            @(posedge clk_100Mhz);
            w++;
        end
        if (w >= 2000) fail_now("tx_frame_wait_expired");
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_temperature"}, temperature, 8'd0);
        check({tag, "_humidity"}, humidity, 8'd0);
        check({tag, "_frame_valid"}, frame_valid, 1'b0);
        check({tag, "_frame_error"}, frame_error, 1'b0);
        check({tag, "_cmd_busy"}, cmd_busy, 1'b0);
        check({tag, "_tx_send"}, tx_send, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] fr[$];
        int         mode, pos, w;
        logic [7:0] b;
        bit         err;

        repeat (3) @(posedge clk_100Mhz);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Slow, well-formed frame.
        send_str("S:2365\n", 1000);
        // Bad digit, then a recovery frame.
        send_str("S:2A65\n", 7);
        send_str("S:0099\n", 3);
        // Broken frame with resync on the second 'S'.
        send_str("S:1S:4050\n", 4);
        // Truncated frame that times out, then a clean frame.
        send_str("S:12", 5);
        timeout_idle();
        send_str("S:7788\n", 2);
        // Line error on the third byte.
        send_byte(8'h53, 1'b0, 3);
        send_byte(8'h3A, 1'b0, 3);
        send_byte(8'h33, 1'b1, 3);
        send_str("456\n", 3);
        send_str("S:1234\n", 2);

        // LED command with a rejected second request mid-frame.
        send_cmd(2'b10);
        repeat (120) @(posedge clk_100Mhz);
        poke_cmd();
        wait_tx_idle();
        repeat (100) @(posedge clk_100Mhz);
        #1;
        check("no_extra_frame", tx_send, 1'b0);

        // Reset in the middle of an RX frame (in DIG2) and the third TX byte.
        send_cmd(2'b01);
        send_str("S:12", 5);
        w = 0;
        while (!(tx_pos == 2 && tx_wait > 10) && w < 2000) begin
            @(posedge clk_100Mhz);
            w++;
        end
        if (w >= 2000) fail_now("tx_third_byte_wait_expired");
        @(posedge clk_100Mhz);
        #1;
        rst = 1'b1;
        fbuf.delete();
        tx_led_q.delete();
        good_t = 8'd0;
        good_h = 8'd0;
        @(posedge clk_100Mhz);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        send_str("S:5566\n", 3);
        send_cmd(2'b11);
        wait_tx_idle();

        // Randomised mix of good, corrupted, errored, truncated and noisy frames.
        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 5);
            fr.delete();
            fr.push_back(8'h53);
            fr.push_back(8'h3A);
            for (int d = 0; d < 4; d++) fr.push_back(8'(8'h30 + $urandom_range(0, 9)));
            fr.push_back(8'h0A);
            pos = $urandom_range(0, 6);
            if (mode == 5) begin
                for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0, $urandom_range(1, 15));
            end
            for (int i = 0; i < 7; i++) begin
                if (mode == 4 && i == pos) break;
                b   = (mode == 2 && i == pos) ? 8'($urandom) : fr[i];
                err = (mode == 3 && i == pos);
                send_byte(b, err, $urandom_range(1, 15));
            end
            if (mode == 4) timeout_idle();
            if (!tx_model_busy() && $urandom_range(0, 2) == 0) send_cmd(2'($urandom));
        end

        wait_tx_idle();
        timeout_idle();
        repeat (20) @(posedge clk_100Mhz);
        #1;
        check("rx_events_pending", rx_q.size(), 0);
        check("tx_frames_pending", tx_model_busy(), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
